// File: rtl/edge_timer_pkg.sv
// rtl/edge_timer_pkg.sv - shared constants and period sizing helpers for edge_timer
package edge_timer_pkg;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;
  localparam logic YES  = 1'b1;
  localparam logic NO   = 1'b0;

  // Clock edges per timer period; zero signals an unusable rate pair.
  function automatic int timer_count(input int clk_hz, input int timer_hz);
    if (timer_hz <= 0) return 0;
    return clk_hz / timer_hz;
  endfunction

  function automatic int count_width(input int count);
    return (count < 1) ? 1 : $clog2(count + 1);
  endfunction

endpackage

// File: rtl/edge_timer_period_counter.sv
// rtl/edge_timer_period_counter.sv - clearable, pausable counter with sticky elapsed flag
module edge_timer_period_counter
  import edge_timer_pkg::*;
#(
  parameter int COUNT = 10,
  parameter int CW    = 4
) (
  input  logic clk,
  input  logic reset_low,
  input  logic clear,
  input  logic enabled,
  output logic finished
);

  localparam logic [CW-1:0] LAST = CW'(COUNT);

  logic [CW-1:0] cnt_q;

  // Counter saturates at LAST because increments stop once finished is set.
  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      cnt_q    <= '0;
      finished <= NO;
    end else if (clear) begin
      cnt_q    <= '0;
      finished <= NO;
    end else if (enabled && !finished) begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == LAST - 1'b1) finished <= YES;
    end
  end

endmodule

// File: rtl/edge_timer.sv
// rtl/edge_timer.sv - level synchroniser with edge strobes plus one period timer
module edge_timer
  import edge_timer_pkg::*;
#(
  parameter int   CLK_HZ      = 51_800_000,
  parameter int   TIMER_HZ    = 10_000,
  parameter logic IDLE_LEVEL  = HIGH,
  parameter int   SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_low,
  input  logic level,
  output logic level_sync,
  output logic pos_edge,
  output logic neg_edge,
  output logic any_edge,
  input  logic clear,
  input  logic enabled,
  output logic finished
);

  localparam int COUNT = timer_count(CLK_HZ, TIMER_HZ);
  localparam int CW    = count_width(COUNT);

  if (COUNT < 1) begin : g_bad_count
    $error("edge_timer: CLK_HZ / TIMER_HZ must be at least 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("edge_timer: SYNC_STAGES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // History resets to the idle level so release never fakes an edge.
  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
      prev_q <= IDLE_LEVEL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], level};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_sync = sync_q[SYNC_STAGES-1];
  assign pos_edge   = level_sync & ~prev_q;
  assign neg_edge   = ~level_sync & prev_q;
  assign any_edge   = pos_edge | neg_edge;

  edge_timer_period_counter #(
    .COUNT (COUNT),
    .CW    (CW)
  ) u_period_counter (
    .clk       (clk),
    .reset_low (reset_low),
    .clear     (clear),
    .enabled   (enabled),
    .finished  (finished)
  );

endmodule

// File: tb/tb_edge_timer.sv
// tb/tb_edge_timer.sv - scoreboard bench for edge_timer
module tb_edge_timer;

  logic clk = 1'b0;
  logic reset_low, level, clear, enabled;
  logic level_sync, pos_edge, neg_edge, any_edge, finished;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int toggles = 0;
  int pushed_edges = 0;
  int seen_edges = 0;
  logic prev_fin = 1'b0;

  typedef struct {
    bit is_pos;
    int cyc;
  } edge_exp_t;

  typedef struct {
    bit val;
    int cyc;
  } fin_exp_t;

  edge_exp_t edge_q[$];
  fin_exp_t  fin_q[$];

  edge_timer #(
    .CLK_HZ      (1000),
    .TIMER_HZ    (100),
    .IDLE_LEVEL  (1'b1),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .reset_low  (reset_low),
    .level      (level),
    .level_sync (level_sync),
    .pos_edge   (pos_edge),
    .neg_edge   (neg_edge),
    .any_edge   (any_edge),
    .clear      (clear),
    .enabled    (enabled),
    .finished   (finished)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_edge(input bit is_pos, input int at);
    edge_exp_t e;
    e.is_pos = is_pos;
    e.cyc = at;
    edge_q.push_back(e);
    pushed_edges++;
  endtask

  task automatic push_fin(input bit val, input int at);
    fin_exp_t f;
    f.val = val;
    f.cyc = at;
    fin_q.push_back(f);
  endtask

  // Monitor: every strobe and every change of finished must match the head of its queue.
  always @(negedge clk) begin
    if (!reset_low) begin
      prev_fin = 1'b0;
    end else begin
      if (pos_edge || neg_edge || any_edge) begin
        seen_edges++;
        if (edge_q.size() == 0) begin
          chk("unexpected_strobe", 1, 0);
        end else begin
          edge_exp_t e;
          e = edge_q.pop_front();
          chk("strobe_cycle", cyc, e.cyc);
          chk("pos_edge", int'(pos_edge), int'(e.is_pos));
          chk("neg_edge", int'(neg_edge), int'(!e.is_pos));
          chk("any_edge", int'(any_edge), 1);
        end
      end
      if (finished !== prev_fin) begin
        if (fin_q.size() == 0) begin
          chk("unexpected_finished_change", int'(finished), int'(prev_fin));
        end else begin
          fin_exp_t f;
          f = fin_q.pop_front();
          chk("finished_cycle", cyc, f.cyc);
          chk("finished_value", int'(finished), int'(f.val));
        end
      end
      prev_fin = finished;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int gaps[12];
    gaps = '{3, 5, 7, 4, 6, 3, 7, 5, 4, 6, 3, 5};

    reset_low = 1'b0;
    level = 1'b1;
    clear = 1'b0;
    enabled = 1'b0;
    step(2);
    chk("reset_level_sync", int'(level_sync), 1);
    chk("reset_pos_edge", int'(pos_edge), 0);
    chk("reset_neg_edge", int'(neg_edge), 0);
    chk("reset_any_edge", int'(any_edge), 0);
    chk("reset_finished", int'(finished), 0);
    reset_low = 1'b1;
    step(5);
    chk("idle_level_sync", int'(level_sync), 1);

    // Edge latency: change at negedge N -> strobe observed at negedge N+2.
    n = cyc;
    level = 1'b0;
    push_edge(1'b0, n + 2);
    step(6);
    n = cyc;
    level = 1'b1;
    push_edge(1'b1, n + 2);
    step(6);

    // Clear pulse then continuous enable: finished after 10 enabled edges.
    n = cyc;
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    enabled = 1'b1;
    push_fin(1'b1, n + 11);
    step(10);
    step(20);
    chk("finished_sticky", int'(finished), 1);
    enabled = 1'b0;
    step(1);

    // 4 enabled, 5 paused, then 6 more enabled.
    n = cyc;
    clear = 1'b1;
    push_fin(1'b0, n + 1);
    step(1);
    clear = 1'b0;
    enabled = 1'b1;
    step(4);
    enabled = 1'b0;
    step(5);
    enabled = 1'b1;
    push_fin(1'b1, n + 16);
    step(8);

    // clear wins over enabled.
    n = cyc;
    clear = 1'b1;
    push_fin(1'b0, n + 1);
    step(5);
    chk("clear_over_enabled", int'(finished), 0);
    clear = 1'b0;
    enabled = 1'b0;
    step(2);

    // Reach finished=1 with level low, then reset asynchronously.
    n = cyc;
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    enabled = 1'b1;
    level = 1'b0;
    push_fin(1'b1, n + 11);
    push_edge(1'b0, n + 3);
    step(12);
    chk("pre_reset_level_sync", int'(level_sync), 0);
    chk("pre_reset_finished", int'(finished), 1);
    #3;
    reset_low = 1'b0;
    #1;
    chk("async_finished", int'(finished), 0);
    chk("async_level_sync", int'(level_sync), 1);
    chk("async_pos_edge", int'(pos_edge), 0);
    chk("async_neg_edge", int'(neg_edge), 0);
    chk("async_any_edge", int'(any_edge), 0);
    enabled = 1'b0;
    step(2);
    n = cyc;
    reset_low = 1'b1;
    push_edge(1'b0, n + 2);
    step(1);
    chk("resync_level_sync", int'(level_sync), 1);
    step(4);

    // Toggle train with fixed gaps of 3..7 cycles.
    foreach (gaps[i]) begin
      n = cyc;
      level = ~level;
      push_edge(level, n + 2);
      toggles++;
      step(gaps[i]);
    end
    step(5);

    chk("edge_queue_drained", edge_q.size(), 0);
    chk("fin_queue_drained", fin_q.size(), 0);
    chk("strobe_count", seen_edges, pushed_edges);
    chk("toggle_strobes", seen_edges - (pushed_edges - toggles), toggles);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
